// File: rtl/t03_display_pkg.sv
// Shared constants and types for the sprite display path.
// Holds the screen origin offsets, active-area limits, colour width and
// the transparent colour key used by the sprite renderer.
package t03_display_pkg;

  localparam int unsigned COORD_W = 11;
  localparam int unsigned COLOR_W = 8;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOR_W-1:0] color_t;

  localparam coord_t X_ORIGIN    = 11'd37;
  localparam coord_t Y_ORIGIN    = 11'd29;
  localparam coord_t H_ACTIVE    = 11'd640;
  localparam coord_t V_ACTIVE    = 11'd480;
  localparam color_t TRANSPARENT = 8'h00;

  // Counter width for a modulus of n, never below one bit.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/t03_sprite_scan_ctr.sv
// Per-sprite scan counter.
// Latches the sprite position/enable/mirror at frame start, tracks the
// vertical (vact/row/sy/row_base) and horizontal (hact/col/sx) window
// using only increments and compares, and reports the bitmap pixel index
// and window flag for the pixel presented on the previous clock.
// Ports:
//   clk, rst      pixel clock, synchronous active-low reset
//   Hcnt, Vcnt    raster position
//   x_in, y_in    sprite offsets (live, latched at frame start)
//   en_in         sprite enable (live, latched at frame start)
//   mirror_in     horizontal flip (live, latched at frame start)
//   pix_idx       row-major bitmap index for the current window pixel
//   win           window covers the pixel and the sprite is enabled
module t03_sprite_scan_ctr
  import t03_display_pkg::*;
#(
  parameter int unsigned SPR_W   = 15,
  parameter int unsigned SPR_H   = 20,
  parameter int unsigned SCALE_X = 1,
  parameter int unsigned SCALE_Y = 5,
  parameter int unsigned IDX_W   = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] Hcnt,
  input  logic [COORD_W-1:0] Vcnt,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               en_in,
  input  logic               mirror_in,
  output logic [IDX_W-1:0]   pix_idx,
  output logic               win
);

  localparam int unsigned COL_W = ctr_w(SPR_W);
  localparam int unsigned ROW_W = ctr_w(SPR_H);
  localparam int unsigned SXW   = ctr_w(SCALE_X);
  localparam int unsigned SYW   = ctr_w(SCALE_Y);

  coord_t             x_sh, y_sh;
  logic               en_sh, mir_sh;
  logic               vact, hact;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [SXW-1:0]     sx;
  logic [SYW-1:0]     sy;
  logic [IDX_W-1:0]   row_base;
  coord_t             xs, ys;
  logic [COL_W-1:0]   col_eff;

  assign xs = x_sh + X_ORIGIN;
  assign ys = y_sh + Y_ORIGIN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_sh     <= '0;
      y_sh     <= '0;
      en_sh    <= 1'b0;
      mir_sh   <= 1'b0;
      vact     <= 1'b0;
      hact     <= 1'b0;
      row      <= '0;
      col      <= '0;
      sx       <= '0;
      sy       <= '0;
      row_base <= '0;
    end else begin
      if (Hcnt == '0 && Vcnt == '0) begin
        x_sh   <= x_in;
        y_sh   <= y_in;
        en_sh  <= en_in;
        mir_sh <= mirror_in;
      end

      // Line step: row_base accumulates SPR_W per source row so the
      // pixel index never needs a multiply.
      if (Hcnt == '0) begin
        if (Vcnt >= V_ACTIVE) begin
          vact <= 1'b0;
        end else if (Vcnt == ys) begin
          vact     <= 1'b1;
          row      <= '0;
          sy       <= '0;
          row_base <= '0;
        end else if (vact) begin
          if (sy == SYW'(SCALE_Y - 1)) begin
            sy <= '0;
            if (row == ROW_W'(SPR_H - 1)) begin
              vact <= 1'b0;
            end else begin
              row      <= row + 1'b1;
              row_base <= row_base + IDX_W'(SPR_W);
            end
          end else begin
            sy <= sy + 1'b1;
          end
        end
      end

      // hact describes the pixel at the Hcnt just sampled, so clearing at
      // H_ACTIVE keeps column H_ACTIVE-1 and nothing carries into the next line.
      if (Hcnt >= H_ACTIVE) begin
        hact <= 1'b0;
      end else if (vact && Hcnt == xs) begin
        hact <= 1'b1;
        col  <= '0;
        sx   <= '0;
      end else if (hact) begin
        if (sx == SXW'(SCALE_X - 1)) begin
          sx <= '0;
          if (col == COL_W'(SPR_W - 1)) begin
            hact <= 1'b0;
          end else begin
            col <= col + 1'b1;
          end
        end else begin
          sx <= sx + 1'b1;
        end
      end
    end
  end

  assign col_eff = mir_sh ? (COL_W'(SPR_W - 1) - col) : col;
  assign pix_idx = row_base + IDX_W'(col_eff);
  assign win     = hact & en_sh;

endmodule

// File: rtl/t03_sprite_display.sv
// Multi-sprite pixel renderer for the VGA path.
// One scan counter per sprite (stage 1), then bitmap lookup, fixed
// priority (index 0 highest, transparent pixels fall through) and output
// registers (stage 2). Outputs describe the raster position presented two
// clocks earlier.
// Ports:
//   clk, rst        pixel clock, synchronous active-low reset
//   Hcnt, Vcnt      raster position
//   sprite_pix      flat bitmaps, sprite s pixel p at [(s*SPR_W*SPR_H+p)*8 +: 8]
//   sprite_x/y      per-sprite offsets from the screen origin
//   sprite_en       per-sprite enable
//   sprite_mirror   per-sprite horizontal flip
//   color           RGB332 output, 0 when nothing is drawn
//   hit             per-sprite window coverage (transparent pixels included)
//   any_displayed   colour came from a non-transparent sprite pixel
module t03_sprite_display
  import t03_display_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = 2,
  parameter int unsigned SPR_W       = 15,
  parameter int unsigned SPR_H       = 20,
  parameter int unsigned SCALE_X     = 1,
  parameter int unsigned SCALE_Y     = 5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COORD_W-1:0]                     Hcnt,
  input  logic [COORD_W-1:0]                     Vcnt,
  input  logic [NUM_SPRITES*SPR_W*SPR_H*8-1:0]   sprite_pix,
  input  logic [NUM_SPRITES*COORD_W-1:0]         sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0]         sprite_y,
  input  logic [NUM_SPRITES-1:0]                 sprite_en,
  input  logic [NUM_SPRITES-1:0]                 sprite_mirror,
  output logic [COLOR_W-1:0]                     color,
  output logic [NUM_SPRITES-1:0]                 hit,
  output logic                                   any_displayed
);

  localparam int unsigned NPIX  = SPR_W * SPR_H;
  localparam int unsigned IDX_W = ctr_w(NPIX);
  localparam int unsigned BUS_W = NUM_SPRITES * NPIX * COLOR_W;
  localparam int unsigned POS_W = ctr_w(BUS_W);

  logic [IDX_W-1:0]                  pix_idx [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]            win;
  logic [NUM_SPRITES-1:0][COLOR_W-1:0] pix_val;
  logic                              active1;
  color_t                            sel_color;
  logic                              sel_any;

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_spr
    localparam int unsigned BASE = s * NPIX * COLOR_W;
    logic [POS_W-1:0] bitpos;

    t03_sprite_scan_ctr #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .SCALE_X (SCALE_X),
      .SCALE_Y (SCALE_Y),
      .IDX_W   (IDX_W)
    ) u_scan (
      .clk       (clk),
      .rst       (rst),
      .Hcnt      (Hcnt),
      .Vcnt      (Vcnt),
      .x_in      (sprite_x[s*COORD_W +: COORD_W]),
      .y_in      (sprite_y[s*COORD_W +: COORD_W]),
      .en_in     (sprite_en[s]),
      .mirror_in (sprite_mirror[s]),
      .pix_idx   (pix_idx[s]),
      .win       (win[s])
    );

    assign bitpos     = POS_W'(BASE) + POS_W'(pix_idx[s]) * POS_W'(COLOR_W);
    assign pix_val[s] = sprite_pix[bitpos +: COLOR_W];
  end

  // First enabled, covering, non-transparent sprite in index order wins.
  always_comb begin
    sel_color = TRANSPARENT;
    sel_any   = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (!sel_any && win[i] && pix_val[i] != TRANSPARENT) begin
        sel_color = pix_val[i];
        sel_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      active1       <= 1'b0;
      color         <= '0;
      hit           <= '0;
      any_displayed <= 1'b0;
    end else begin
      active1       <= (Hcnt < H_ACTIVE) && (Vcnt < V_ACTIVE);
      color         <= active1 ? sel_color : '0;
      hit           <= active1 ? win : '0;
      any_displayed <= active1 & sel_any;
    end
  end

endmodule
